// File: rtl/claudiotalarico_spi_counter_pkg.sv
// Shared opcodes, control-register layout and frame geometry for the SPI counter.
package claudiotalarico_spi_counter_pkg;

  localparam logic [7:0] CMD_WR_COUNT = 8'h01;
  localparam logic [7:0] CMD_RD_COUNT = 8'h02;
  localparam logic [7:0] CMD_WR_CTRL  = 8'h03;
  localparam logic [7:0] CMD_WR_PRESC = 8'h04;

  localparam int unsigned CTRL_RUN = 0;
  localparam int unsigned CTRL_UP  = 1;
  localparam int unsigned CTRL_SAT = 2;

  localparam logic [7:0] CTRL_RESET = 8'h02;

  localparam int unsigned FRAME_BITS = 16;

endpackage

// File: rtl/claudiotalarico_spi_resp.sv
// SPI mode-0 responder: synchronizes the host pins, assembles the command/data frame
// and shifts a count snapshot out on miso during the data byte.
module claudiotalarico_spi_resp
  import claudiotalarico_spi_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic             cs_n_in,
  input  logic             mosi_in,
  input  logic [WIDTH-1:0] snapshot,
  output logic [WIDTH-1:0] cmd,
  output logic [WIDTH-1:0] data,
  output logic             frame_done,
  output logic             rd_req,
  output logic             miso,
  output logic             frame_active
);

  localparam int unsigned CntW = $clog2(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_s, cs_s, mosi_s, sclk_prev_q;
  logic                   rise, fall;
  logic [CntW-1:0]        bit_cnt_q;
  logic [WIDTH-1:0]       sh_q, cmd_q, tx_q, next_sh;
  logic                   frame_done_q, miso_q, frame_active_q;
  logic                   is_read;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign next_sh = {sh_q[WIDTH-2:0], mosi_s};
  assign is_read = (cmd_q == WIDTH'(CMD_RD_COUNT));

  // Strobe on the 8th rise of a read so the top can freeze the count for the data byte.
  assign rd_req = ~cs_s & rise & (bit_cnt_q == CntW'(WIDTH - 1))
                & (next_sh == WIDTH'(CMD_RD_COUNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q    <= '0;
      cs_sync_q      <= '1;
      mosi_sync_q    <= '0;
      sclk_prev_q    <= 1'b0;
      bit_cnt_q      <= '0;
      sh_q           <= '0;
      cmd_q          <= '0;
      tx_q           <= '0;
      frame_done_q   <= 1'b0;
      miso_q         <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      sclk_sync_q    <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync_q    <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sclk_prev_q    <= sclk_s;
      frame_active_q <= ~cs_s;
      frame_done_q   <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= '0;
        cmd_q     <= '0;
        miso_q    <= 1'b0;
      end else begin
        if (rise && (bit_cnt_q < CntW'(FRAME_BITS))) begin
          sh_q      <= next_sh;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CntW'(WIDTH - 1)) cmd_q <= next_sh;
          if (bit_cnt_q == CntW'(FRAME_BITS - 1)) frame_done_q <= 1'b1;
        end
        if (fall) begin
          if (is_read && (bit_cnt_q == CntW'(WIDTH))) begin
            tx_q   <= snapshot;
            miso_q <= snapshot[WIDTH-1];
          end else if (is_read && (bit_cnt_q > CntW'(WIDTH))
                       && (bit_cnt_q < CntW'(FRAME_BITS))) begin
            tx_q   <= tx_q << 1;
            miso_q <= tx_q[WIDTH-2];
          end else begin
            miso_q <= 1'b0;
          end
        end
      end
    end
  end

  assign cmd          = cmd_q;
  assign data         = sh_q;
  assign frame_done   = frame_done_q;
  assign miso         = miso_q;
  assign frame_active = frame_active_q;

endmodule

// File: rtl/tt_um_claudiotalarico_spi_counter.sv
// Tiny Tapeout top: SPI-programmed up/down counter with prescaler, count shown on uo_out.
module tt_um_claudiotalarico_spi_counter
  import claudiotalarico_spi_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [WIDTH-1:0] cmd, data;
  logic             frame_done, rd_req, miso, frame_active;
  logic [WIDTH-1:0] ctrl_q, presc_q, count_q, count_d, pcnt_q, pcnt_d, snap_q;
  logic             wr_count, wr_ctrl, wr_presc, tick;
  logic             unused_inputs;

  assign unused_inputs = &{1'b0, ena, ui_in[7:3], uio_in};

  claudiotalarico_spi_resp #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_resp (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk_in      (ui_in[0]),
    .cs_n_in      (ui_in[1]),
    .mosi_in      (ui_in[2]),
    .snapshot     (snap_q),
    .cmd          (cmd),
    .data         (data),
    .frame_done   (frame_done),
    .rd_req       (rd_req),
    .miso         (miso),
    .frame_active (frame_active)
  );

  assign wr_count = frame_done && (cmd == WIDTH'(CMD_WR_COUNT));
  assign wr_ctrl  = frame_done && (cmd == WIDTH'(CMD_WR_CTRL));
  assign wr_presc = frame_done && (cmd == WIDTH'(CMD_WR_PRESC));

  always_comb begin
    pcnt_d  = pcnt_q;
    count_d = count_q;
    tick    = ctrl_q[CTRL_RUN] && (pcnt_q == presc_q);
    if (!ctrl_q[CTRL_RUN] || wr_presc || tick) pcnt_d = '0;
    else                                       pcnt_d = pcnt_q + 1'b1;
    // A host load takes priority over a step landing in the same cycle.
    if (wr_count) begin
      count_d = data;
    end else if (tick) begin
      if (ctrl_q[CTRL_UP]) begin
        if (!(ctrl_q[CTRL_SAT] && (count_q == '1))) count_d = count_q + 1'b1;
      end else begin
        if (!(ctrl_q[CTRL_SAT] && (count_q == '0))) count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= WIDTH'(CTRL_RESET);
      presc_q <= '0;
      count_q <= '0;
      pcnt_q  <= '0;
      snap_q  <= '0;
    end else begin
      if (wr_ctrl)  ctrl_q  <= data;
      if (wr_presc) presc_q <= data;
      if (rd_req)   snap_q  <= count_q;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign uo_out  = 8'(count_q);
  assign uio_out = {6'b0, frame_active, miso};
  assign uio_oe  = 8'b0000_0011;

endmodule

// File: tb/tb_tt_um_claudiotalarico_spi_counter.sv
// Self-checking bench for the SPI counter: host-side SPI tasks plus an expected-value queue.
module tb_tt_um_claudiotalarico_spi_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  assign ui_in  = {5'b0, mosi, cs_n, sclk};
  assign uio_in = 8'h00;

  tt_um_claudiotalarico_spi_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Clocks nbits bits of {c,d}; leaves sclk high after the last rise.
  task automatic spi_bits(input logic [7:0] c, input logic [7:0] d, input int nbits,
                          output logic [7:0] rx);
    logic [15:0] w;
    w  = {c, d};
    rx = 8'h00;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[15-i];
      repeat (6) @(negedge clk);
      if (i >= 8) rx[15-i] = uio_out[0];
      sclk = 1'b1;
      if (i != nbits - 1) begin
        repeat (4) @(negedge clk);
        sclk = 1'b0;
      end
    end
  endtask

  task automatic spi_end();
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_write(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] rx;
    spi_bits(c, d, 16, rx);
    spi_end();
  endtask

  task automatic test_reset();
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL reset_uo_out got=%h exp=00", uo_out);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      errors++; $display("FAIL reset_uio_out got=%h exp=00", uio_out);
    end
    checks++;
    if (uio_oe !== 8'h03) begin
      errors++; $display("FAIL uio_oe got=%h exp=03", uio_oe);
    end
  endtask

  task automatic test_write_count();
    spi_write(8'h01, 8'h5A);
    checks++;
    if (uo_out !== 8'h5A) begin
      errors++; $display("FAIL wr_count got=%h exp=5a", uo_out);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (uo_out !== 8'h5A) begin
      errors++; $display("FAIL wr_count_hold got=%h exp=5a", uo_out);
    end
  endtask

  task automatic test_read();
    logic [7:0] rx, e;
    spi_write(8'h01, 8'h10);
    exp_q.push_back(8'h10);
    spi_bits(8'h02, 8'h00, 16, rx);
    checks++;
    if (uio_out[1] !== 1'b1) begin
      errors++; $display("FAIL frame_active_low got=%b exp=1", uio_out[1]);
    end
    spi_end();
    e = exp_q.pop_front();
    checks++;
    if (rx !== e) begin
      errors++; $display("FAIL rd_count got=%h exp=%h", rx, e);
    end
    checks++;
    if (uio_out[1:0] !== 2'b00) begin
      errors++; $display("FAIL idle_miso_active got=%b exp=00", uio_out[1:0]);
    end
  endtask

  task automatic test_down_wrap_and_sat();
    logic [7:0] rx, e;
    int n;
    spi_write(8'h01, 8'h01);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFE);
    spi_bits(8'h03, 8'h01, 16, rx);
    n = 0;
    while (uo_out == 8'h01 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL run_start_timeout got=%0d exp<20", n);
    end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (uo_out !== e) begin
        errors++; $display("FAIL down_wrap[%0d] got=%h exp=%h", k, uo_out, e);
      end
      @(negedge clk);
    end
    spi_end();
    spi_write(8'h03, 8'h00);
    spi_write(8'h01, 8'hFD);
    spi_write(8'h03, 8'h07);
    repeat (10) @(negedge clk);
    checks++;
    if (uo_out !== 8'hFF) begin
      errors++; $display("FAIL sat_up got=%h exp=ff", uo_out);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (uo_out !== 8'hFF) begin
      errors++; $display("FAIL sat_hold got=%h exp=ff", uo_out);
    end
  endtask

  task automatic test_prescale();
    logic [7:0] rx, e;
    int n;
    spi_write(8'h03, 8'h02);
    spi_write(8'h04, 8'h03);
    spi_write(8'h01, 8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h0A);
    spi_bits(8'h03, 8'h03, 16, rx);
    n = 0;
    while (uo_out == 8'h00 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++; $display("FAIL presc_start_timeout got=%0d exp<30", n);
    end
    repeat (3) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (uo_out !== e) begin
      errors++; $display("FAIL presc_hold got=%h exp=%h", uo_out, e);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (uo_out !== e) begin
      errors++; $display("FAIL presc_step got=%h exp=%h", uo_out, e);
    end
    repeat (32) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (uo_out !== e) begin
      errors++; $display("FAIL presc_40 got=%h exp=%h", uo_out, e);
    end
    spi_end();
    spi_write(8'h03, 8'h02);
    spi_write(8'h04, 8'h00);
  endtask

  task automatic test_abort_and_bad_opcode();
    logic [7:0] rx, e;
    spi_write(8'h01, 8'h44);
    spi_bits(8'h01, 8'h99, 12, rx);
    spi_end();
    checks++;
    if (uo_out !== 8'h44) begin
      errors++; $display("FAIL abort got=%h exp=44", uo_out);
    end
    spi_write(8'h01, 8'h33);
    checks++;
    if (uo_out !== 8'h33) begin
      errors++; $display("FAIL after_abort got=%h exp=33", uo_out);
    end
    exp_q.push_back(8'h00);
    spi_bits(8'h7E, 8'h55, 16, rx);
    spi_end();
    e = exp_q.pop_front();
    checks++;
    if (rx !== e) begin
      errors++; $display("FAIL bad_op_miso got=%h exp=%h", rx, e);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (uo_out !== 8'h33) begin
      errors++; $display("FAIL bad_op_count got=%h exp=33", uo_out);
    end
    exp_q.push_back(8'h33);
    spi_bits(8'h02, 8'h00, 16, rx);
    spi_end();
    e = exp_q.pop_front();
    checks++;
    if (rx !== e) begin
      errors++; $display("FAIL bad_op_readback got=%h exp=%h", rx, e);
    end
  endtask

  task automatic test_load_priority_and_reset();
    logic [7:0] rx, e;
    int n;
    spi_write(8'h03, 8'h07);
    repeat (260) @(negedge clk);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h82);
    spi_bits(8'h01, 8'h80, 16, rx);
    checks++;
    if (uo_out !== 8'hFF) begin
      errors++; $display("FAIL pre_load got=%h exp=ff", uo_out);
    end
    n = 0;
    while (uo_out == 8'hFF && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL load_timeout got=%0d exp<20", n);
    end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (uo_out !== e) begin
        errors++; $display("FAIL load_prio[%0d] got=%h exp=%h", k, uo_out, e);
      end
      @(negedge clk);
    end
    spi_end();
    spi_bits(8'h01, 8'h22, 5, rx);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++; $display("FAIL async_reset got=%h/%h exp=00/00", uo_out, uio_out);
    end
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL post_reset_idle got=%h exp=00", uo_out);
    end
    spi_write(8'h01, 8'h10);
    repeat (20) @(negedge clk);
    checks++;
    if (uo_out !== 8'h10) begin
      errors++; $display("FAIL post_reset_ctrl got=%h exp=10", uo_out);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_write_count();
    test_read();
    test_down_wrap_and_sat();
    test_prescale();
    test_abort_and_bad_opcode();
    test_load_priority_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
